// File: rtl/dmem_bus_model.sv
// Data-bus memory slave: programmable-latency word store with lane steering,
// alignment/range fault reporting, a buffered stdout byte channel and a sticky exit flag.
module dmem_bus_model #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0800_0000),
  parameter int unsigned       LATENCY     = 1,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = ADDR_W'(32'hf000_0000),
  parameter logic [ADDR_W-1:0] EXIT_ADDR   = ADDR_W'(32'hff00_0000),
  parameter int unsigned       FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mreq,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] dad,
  input  logic [31:0]       ddt_w,
  output logic [31:0]       ddt_r,
  output logic              ackd_n,
  output logic              err,
  output logic              exit_o,
  output logic              so_valid,
  output logic [7:0]        so_data,
  input  logic              so_ready
);
  localparam int unsigned   IW        = $clog2(DEPTH_WORDS);
  localparam int unsigned   AW        = IW + 2;
  localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   LW        = PW + 1;
  localparam int unsigned   CW        = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT  = (LATENCY > 1) ? CW'(LATENCY - 1) : CW'(1);
  localparam logic [LW-1:0] FIFO_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              cur_write;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic              in_mem, is_so, is_exit, fault, so_store, stall, do_ack;
  logic              push, pop, mem_we;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IW-1:0]     word_idx;
  logic [1:0]        byte_sel;
  logic [31:0]       rd_word, load_word, wr_word;
  logic [3:0]        be;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_n;
  logic [LW-1:0]     level, level_n;
  logic [7:0]        head_n;

  // In IDLE the live bus is decoded so a one-cycle latency can ack on the sample edge
  always_comb begin
    if (state == IDLE) begin
      cur_write = write;
      cur_size  = size;
      cur_addr  = dad;
      cur_wdata = ddt_w;
    end else begin
      cur_write = r_write;
      cur_size  = r_size;
      cur_addr  = r_addr;
      cur_wdata = r_wdata;
    end
  end

  assign in_mem  = cur_addr[ADDR_W-1:AW] == BASE_ADDR[ADDR_W-1:AW];
  assign is_so   = cur_addr == STDOUT_ADDR;
  assign is_exit = cur_addr == EXIT_ADDR;

  always_comb begin
    fault = 1'b0;
    if (cur_size == 2'b11)                                fault = 1'b1;
    else if (cur_size == 2'b01 && cur_addr[0])            fault = 1'b1;
    else if (cur_size == 2'b00 && cur_addr[1:0] != 2'b00) fault = 1'b1;
    else if (!in_mem && !is_so && !is_exit)               fault = 1'b1;
    else if (is_so && cur_write && cur_size != 2'b10)     fault = 1'b1;
  end

  assign so_store = is_so && cur_write && !fault;
  assign stall    = so_store && (level == FIFO_FULL);
  assign do_ack   = !stall && ((state == IDLE && mreq && LATENCY == 1) ||
                               (state == WAIT && cnt <= CW'(1)));
  assign push     = (state == ACK) && so_store;
  assign pop      = so_valid && so_ready;
  assign mem_we   = (state == ACK) && cur_write && in_mem && !fault;

  // Lane steering: byte offset k lives in bits [8k+7:8k]
  assign word_idx = cur_addr[AW-1:2];
  assign byte_sel = cur_addr[1:0];
  assign rd_word  = mem[word_idx];

  always_comb begin
    load_word = '0;
    wr_word   = '0;
    be        = '0;
    case (cur_size)
      2'b00: begin
        load_word = rd_word;
        wr_word   = cur_wdata;
        be        = 4'b1111;
      end
      2'b01: begin
        load_word = cur_addr[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
        wr_word   = {2{cur_wdata[15:0]}};
        be        = cur_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        load_word = {24'h0, rd_word[{byte_sel, 3'b000} +: 8]};
        wr_word   = {4{cur_wdata[7:0]}};
        be        = 4'b0001 << byte_sel;
      end
      default: ;
    endcase
  end

  // Next FIFO head; a byte pushed into the slot becoming head bypasses the array
  always_comb begin
    rd_ptr_n = rd_ptr + PW'(pop);
    level_n  = level + LW'(push) - LW'(pop);
    head_n   = (push && rd_ptr_n == wr_ptr) ? r_wdata[7:0] : fifo_mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      ackd_n   <= 1'b1;
      err      <= 1'b0;
      ddt_r    <= '0;
      exit_o   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      so_valid <= 1'b0;
      so_data  <= '0;
    end else begin
      ackd_n <= 1'b1;
      err    <= 1'b0;
      case (state)
        IDLE: if (mreq) begin
          r_write <= write;
          r_size  <= size;
          r_addr  <= dad;
          r_wdata <= ddt_w;
          cnt     <= CNT_INIT;
          state   <= do_ack ? ACK : WAIT;
        end
        WAIT: begin
          if (cnt > CW'(1)) cnt <= cnt - CW'(1);
          else if (do_ack)  state <= ACK;
        end
        ACK: begin
          state <= IDLE;
          if (cur_write && is_exit && !fault) exit_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (do_ack) begin
        ackd_n <= 1'b0;
        err    <= fault;
        if (fault)           ddt_r <= '0;
        else if (!cur_write) ddt_r <= in_mem ? load_word : '0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_n;
      level    <= level_n;
      so_valid <= level_n != '0;
      so_data  <= (level_n != '0) ? head_n : 8'h00;
    end
  end

  // Storage arrays carry no reset; writes commit on the edge that ends ACK
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= r_wdata[7:0];
  end

endmodule

// File: tb/tb_dmem_bus_model.sv
// Bench for dmem_bus_model: directed protocol, fault, stdout FIFO, exit and reset
// steps, then randomized accesses checked against an array-based reference model.
module tb_dmem_bus_model;
  localparam int unsigned LAT   = 3;
  localparam int unsigned FD    = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0800_0000;
  localparam logic [31:0] SO_A  = 32'hf000_0000;
  localparam logic [31:0] EX_A  = 32'hff00_0000;

  logic        clk = 1'b0;
  logic        rst, mreq, write, so_ready;
  logic [1:0]  size;
  logic [31:0] dad, ddt_w, ddt_r;
  logic        ackd_n, err, exit_o, so_valid;
  logic [7:0]  so_data;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] mdl [DEPTH];

  dmem_bus_model #(
    .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT),
    .STDOUT_ADDR(SO_A), .EXIT_ADDR(EX_A), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .mreq(mreq), .write(write), .size(size), .dad(dad),
    .ddt_w(ddt_w), .ddt_r(ddt_r), .ackd_n(ackd_n), .err(err), .exit_o(exit_o),
    .so_valid(so_valid), .so_data(so_data), .so_ready(so_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_in_mem(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic logic ref_fault(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b00 && (a % 4) != 0) return 1'b1;
    if (ref_in_mem(a)) return 1'b0;
    if (a == SO_A) return w && (sz != 2'b10);
    if (a == EX_A) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [1:0] sz);
    return (sz == 2'b00) ? 32'hffff_ffff : (sz == 2'b01) ? 32'h0000_ffff : 32'h0000_00ff;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a);
    if (!ref_in_mem(a)) return 32'h0;
    return (mdl[10'((a - BASE) / 4)] >> (8 * (a % 4))) & ref_mask(sz);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m, sh;
    if (!ref_in_mem(a)) return;
    m  = ref_mask(sz);
    sh = 8 * (a % 4);
    mdl[10'((a - BASE) / 4)] = (mdl[10'((a - BASE) / 4)] & ~(m << sh)) | ((d & m) << sh);
  endtask

  task automatic wait_ack(input int budget, output logic got, output int lat);
    got = 1'b0;
    lat = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      got = !ackd_n;
    end
  endtask

  // Drives one request from a negedge while the slave is idle; returns one cycle after ack
  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output logic e, output int lat);
    logic got;
    mreq = 1'b1; write = w; size = sz; dad = a; ddt_w = d;
    wait_ack(40, got, lat);
    rdata = ddt_r;
    e     = err;
    mreq  = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("ack_single_cycle", 32'(ackd_n), 32'd1);
    chk("err_single_cycle", 32'(err), 32'd0);
  endtask

  task automatic xfer(input string tag, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rdata, exp_data;
    logic        e, exp_err;
    int          lat;
    exp_err  = ref_fault(w, sz, a);
    exp_data = exp_err ? 32'h0 : ref_load(sz, a);
    access(w, sz, a, d, rdata, e, lat);
    chk({tag, "_lat"}, 32'(lat), LAT);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    if (!w || exp_err) chk({tag, "_data"}, rdata, exp_data);
    if (w && !exp_err) ref_store(sz, a, d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got, ack_seen, ack_err;
    int          lat, ack_at, r;
    logic [7:0]  got_q [$];
    logic [1:0]  sz;
    logic [31:0] a;

    rst = 1'b1; mreq = 1'b0; write = 1'b0; size = 2'b00; dad = '0; ddt_w = '0; so_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ackd_n", 32'(ackd_n), 32'd1);
    chk("rst_ddt_r", ddt_r, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_exit", 32'(exit_o), 32'd0);
    chk("rst_so_valid", 32'(so_valid), 32'd0);
    chk("rst_so_data", 32'(so_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word round trip, byte lane update, half readback
    xfer("w_st", 1'b1, 2'b00, BASE + 32'h10, 32'hdeadbeef);
    xfer("w_ld", 1'b0, 2'b00, BASE + 32'h10, 32'h0);
    chk("w_ld_const", ref_load(2'b00, BASE + 32'h10), 32'hdeadbeef);
    xfer("b_st", 1'b1, 2'b10, BASE + 32'h13, 32'h0000_005a);
    xfer("w_ld2", 1'b0, 2'b00, BASE + 32'h10, 32'h0);
    xfer("h_ld", 1'b0, 2'b01, BASE + 32'h12, 32'h0);
    chk("lane_model", ref_load(2'b01, BASE + 32'h12), 32'h0000_5aad);

    // Faults leave memory untouched
    xfer("h_misal", 1'b0, 2'b01, BASE + 32'h01, 32'h0);
    xfer("w_oor", 1'b1, 2'b00, 32'h0000_0100, 32'h1111_1111);
    xfer("w_misal_st", 1'b1, 2'b00, BASE + 32'h12, 32'h2222_2222);
    xfer("size11", 1'b0, 2'b11, BASE + 32'h10, 32'h0);
    xfer("w_ld3", 1'b0, 2'b00, BASE + 32'h10, 32'h0);

    // Range boundaries
    xfer("last_st", 1'b1, 2'b00, BASE + 32'hffc, 32'hcafe_f00d);
    xfer("last_ld", 1'b0, 2'b00, BASE + 32'hffc, 32'h0);
    xfer("past_end", 1'b1, 2'b00, BASE + 32'h1000, 32'h3333_3333);
    xfer("below_base", 1'b0, 2'b00, BASE - 32'h4, 32'h0);

    // Stdout: load reads zero, non-byte store faults without pushing
    xfer("so_load", 1'b0, 2'b00, SO_A, 32'h0);
    xfer("so_half", 1'b1, 2'b01, SO_A, 32'h0000_0041);
    chk("so_half_nopush", 32'(so_valid), 32'd0);

    // FIFO fills, third store is withheld until space frees
    xfer("so_H", 1'b1, 2'b10, SO_A, 32'h48);
    xfer("so_i", 1'b1, 2'b10, SO_A, 32'h69);
    chk("so_valid_full", 32'(so_valid), 32'd1);
    chk("so_head_H", 32'(so_data), 32'h48);
    mreq = 1'b1; write = 1'b1; size = 2'b10; dad = SO_A; ddt_w = 32'h21;
    wait_ack(8, got, lat);
    chk("so_full_withheld", 32'(got), 32'd0);
    so_ready = 1'b1;
    ack_at = -1;
    ack_err = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (so_valid && so_ready) got_q.push_back(so_data);
      if (!ackd_n && ack_at < 0) begin
        ack_at  = k;
        ack_err = err;
        mreq    = 1'b0;
      end
      @(negedge clk);
    end
    chk("so_release_delay", 32'(ack_at), 32'd2);
    chk("so_third_err", 32'(ack_err), 32'd0);
    chk("so_pop_count", 32'(got_q.size()), 32'd3);
    while (got_q.size() < 3) got_q.push_back(8'h00);
    chk("so_pop0", 32'(got_q[0]), 32'h48);
    chk("so_pop1", 32'(got_q[1]), 32'h69);
    chk("so_pop2", 32'(got_q[2]), 32'h21);
    chk("so_drained", 32'(so_valid), 32'd0);

    // Simultaneous push and pop keeps a single entry
    so_ready = 1'b0;
    xfer("so_A", 1'b1, 2'b10, SO_A, 32'h41);
    mreq = 1'b1; write = 1'b1; size = 2'b10; dad = SO_A; ddt_w = 32'h42;
    wait_ack(40, got, lat);
    chk("so_B_ack", 32'(got), 32'd1);
    so_ready = 1'b1;
    mreq = 1'b0;
    @(negedge clk);
    so_ready = 1'b0;
    chk("pp_valid", 32'(so_valid), 32'd1);
    chk("pp_head", 32'(so_data), 32'h42);
    @(negedge clk);
    chk("pp_level_valid", 32'(so_valid), 32'd1);
    chk("pp_level_head", 32'(so_data), 32'h42);
    so_ready = 1'b1;
    @(negedge clk);
    so_ready = 1'b0;
    chk("pp_empty", 32'(so_valid), 32'd0);

    // Exit flag is sticky; exit load reads zero
    chk("exit_before", 32'(exit_o), 32'd0);
    xfer("exit_st", 1'b1, 2'b00, EX_A, 32'h1);
    chk("exit_set", 32'(exit_o), 32'd1);
    xfer("exit_ld", 1'b0, 2'b00, EX_A, 32'h0);
    repeat (4) @(negedge clk);
    chk("exit_sticky", 32'(exit_o), 32'd1);

    // Reset while a store waits: no ack, no write, exit cleared
    mreq = 1'b1; write = 1'b1; size = 2'b00; dad = BASE + 32'h10; ddt_w = 32'h1234_5678;
    @(negedge clk);
    chk("rst_mid_noack_yet", 32'(ackd_n), 32'd1);
    rst = 1'b1;
    mreq = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (!ackd_n) ack_seen = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!ackd_n) ack_seen = 1'b1;
    end
    chk("rst_mid_noack", 32'(ack_seen), 32'd0);
    chk("rst_mid_exit", 32'(exit_o), 32'd0);
    chk("rst_mid_so_valid", 32'(so_valid), 32'd0);
    xfer("rst_mid_ld", 1'b0, 2'b00, BASE + 32'h10, 32'h0);

    // Randomized accesses over a small window plus occasional out-of-range hits
    for (int i = 0; i < 8; i++) xfer("rnd_init", 1'b1, 2'b00, BASE + 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = BASE + 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h1000 + 32'($urandom_range(0, 7));
      xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
